// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
package arm_ctrl_pkg;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctl_t;

    // Instruction classes (instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing commands (funct[4:1])
    localparam logic [3:0] DP_AND = 4'b0000;
    localparam logic [3:0] DP_SUB = 4'b0010;
    localparam logic [3:0] DP_ADD = 4'b0100;
    localparam logic [3:0] DP_CMP = 4'b1010;
    localparam logic [3:0] DP_ORR = 4'b1100;

    // Datapath mux selects
    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_ALUOUT  = 1'b1;
    localparam logic [1:0] REGSRC_R15  = 2'b01;
    localparam logic [1:0] REGSRC_RD   = 2'b10;
    localparam logic [1:0] IMM_DP      = 2'b00;
    localparam logic [1:0] IMM_MEM     = 2'b01;
    localparam logic [1:0] IMM_BR      = 2'b10;
    localparam logic [1:0] SRCA_RN     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCB_RM     = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_RDATA   = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] RES_PC      = 2'b11;

    // Condition field encodings (instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Control word presented to the datapath
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_src;
        logic [1:0] imm_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_ctl_t   alu_ctl;
        logic [1:0] result_src;
        logic       wa_link;
    } ctrl_t;

    // Map a data-processing command onto the four ALU operations; unknown codes add
    function automatic alu_ctl_t dp_alu_ctl(input logic [3:0] cmd);
        case (cmd)
            DP_ADD:         return ALU_ADD;
            DP_SUB, DP_CMP: return ALU_SUB;
            DP_AND:         return ALU_AND;
            DP_ORR:         return ALU_ORR;
            default:        return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register plus evaluation of the instruction condition field.
module arm_cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_flag_we,
    input  logic [3:0] i_alu_flags,
    input  logic [3:0] i_cond,
    output logic       o_cond_ex
);

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Flags capture the ALU result at the end of a flag-setting execute cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= '0;
        end else if (i_flag_we) begin
            r_flags <= i_alu_flags;
        end
    end

    // Condition check against the latched flags; 1111 never executes
    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = !w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = !w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = !w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = !w_v;
            COND_HI: o_cond_ex = w_c && !w_z;
            COND_LS: o_cond_ex = !w_c || w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = !w_z && (w_n == w_v);
            COND_LE: o_cond_ex = w_z || (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Moore controller for a multicycle ARM datapath with one shared memory port and ALU.
// Outputs decode the state register and are forced low while reset_n is low.
// Optional feature: define ARM_CTRL_BL_EN to make BL write the link register.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_src,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ctl,
    output logic [1:0] result_src,
    output logic       wa_link
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              w_wait_done;
    logic              w_cond_ex;
    logic              w_flag_we;
    logic              w_is_cmp;
    logic              w_is_bl;
    ctrl_t             w_ctrl;

    assign w_wait_done = (r_wait_cnt == WAIT_LAST);
    assign w_is_cmp    = (funct[4:1] == DP_CMP);
    assign w_flag_we   = ((r_state == S_EXECR) || (r_state == S_EXECI)) && funct[0];

`ifdef ARM_CTRL_BL_EN
    assign w_is_bl = funct[4];
`else
    assign w_is_bl = 1'b0;
`endif

    arm_cond_unit u_cond (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flag_we   (w_flag_we),
        .i_alu_flags (alu_flags),
        .i_cond      (cond),
        .o_cond_ex   (w_cond_ex)
    );

    // State sequencing; the wait counter only runs inside memory-access states
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= '0;
            case (r_state)
                S_FETCH: begin
                    if (w_wait_done) r_state <= S_DECODE;
                    else             r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
                S_DECODE: begin
                    if (!w_cond_ex) begin
                        r_state <= S_FETCH;
                    end else begin
                        case (op)
                            OP_MEM:  r_state <= S_MEMADR;
                            OP_BR:   r_state <= S_BRANCH;
                            OP_DP:   r_state <= funct[5] ? S_EXECI : S_EXECR;
                            default: r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:  r_state <= funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: begin
                    if (w_wait_done) r_state <= S_MEMWB;
                    else             r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
                S_MEMWB:   r_state <= S_FETCH;
                S_MEMWRITE: begin
                    if (w_wait_done) r_state <= S_FETCH;
                    else             r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
                S_EXECR:   r_state <= S_ALUWB;
                S_EXECI:   r_state <= S_ALUWB;
                S_ALUWB:   r_state <= S_FETCH;
                S_BRANCH:  r_state <= S_FETCH;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Control word per state; reset_n gating kills every strobe the instant reset asserts
    always_comb begin
        w_ctrl = '0;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    w_ctrl.adr_src    = ADR_PC;
                    w_ctrl.alu_src_a  = SRCA_PC;
                    w_ctrl.alu_src_b  = SRCB_FOUR;
                    w_ctrl.alu_ctl    = ALU_ADD;
                    w_ctrl.result_src = RES_ALU;
                    w_ctrl.ir_write   = w_wait_done;
                    w_ctrl.pc_write   = w_wait_done;
                end
                S_DECODE: begin
                    w_ctrl.alu_src_a  = SRCA_PC;
                    w_ctrl.alu_src_b  = SRCB_FOUR;
                    w_ctrl.alu_ctl    = ALU_ADD;
                end
                S_MEMADR: begin
                    w_ctrl.imm_src    = IMM_MEM;
                    w_ctrl.alu_src_a  = SRCA_RN;
                    w_ctrl.alu_src_b  = SRCB_IMM;
                    w_ctrl.alu_ctl    = ALU_ADD;
                end
                S_MEMREAD: begin
                    w_ctrl.adr_src    = ADR_ALUOUT;
                end
                S_MEMWB: begin
                    w_ctrl.result_src = RES_RDATA;
                    w_ctrl.reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    w_ctrl.adr_src    = ADR_ALUOUT;
                    w_ctrl.reg_src    = REGSRC_RD;
                    w_ctrl.mem_write  = w_wait_done;
                end
                S_EXECR: begin
                    w_ctrl.alu_src_a  = SRCA_RN;
                    w_ctrl.alu_src_b  = SRCB_RM;
                    w_ctrl.alu_ctl    = dp_alu_ctl(funct[4:1]);
                end
                S_EXECI: begin
                    w_ctrl.imm_src    = IMM_DP;
                    w_ctrl.alu_src_a  = SRCA_RN;
                    w_ctrl.alu_src_b  = SRCB_IMM;
                    w_ctrl.alu_ctl    = dp_alu_ctl(funct[4:1]);
                end
                S_ALUWB: begin
                    w_ctrl.result_src = RES_ALUOUT;
                    w_ctrl.reg_write  = !w_is_cmp;
                end
                S_BRANCH: begin
                    w_ctrl.reg_src    = REGSRC_R15;
                    w_ctrl.imm_src    = IMM_BR;
                    w_ctrl.alu_src_a  = SRCA_RN;
                    w_ctrl.alu_src_b  = SRCB_IMM;
                    w_ctrl.alu_ctl    = ALU_ADD;
                    w_ctrl.result_src = w_is_bl ? RES_PC : RES_ALU;
                    w_ctrl.pc_write   = 1'b1;
                    w_ctrl.reg_write  = w_is_bl;
                    w_ctrl.wa_link    = w_is_bl;
                end
                default: w_ctrl = '0;
            endcase
        end
    end

    assign pc_write   = w_ctrl.pc_write;
    assign ir_write   = w_ctrl.ir_write;
    assign adr_src    = w_ctrl.adr_src;
    assign mem_write  = w_ctrl.mem_write;
    assign reg_write  = w_ctrl.reg_write;
    assign reg_src    = w_ctrl.reg_src;
    assign imm_src    = w_ctrl.imm_src;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign alu_ctl    = w_ctrl.alu_ctl;
    assign result_src = w_ctrl.result_src;
    assign wa_link    = w_ctrl.wa_link;

endmodule
